// File: rtl/huffman_pkg.sv
// Shared Huffman definitions: sequencer states, symbol count/width, one-hot symbol codes.
package huffman_pkg;
  localparam int NSYM  = 6;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_REPORT, S_LAUNCH, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [NSYM-1:0] SYM1 = 6'b000001;
  localparam logic [NSYM-1:0] SYM2 = 6'b000010;
  localparam logic [NSYM-1:0] SYM3 = 6'b000100;
  localparam logic [NSYM-1:0] SYM4 = 6'b001000;
  localparam logic [NSYM-1:0] SYM5 = 6'b010000;
  localparam logic [NSYM-1:0] SYM6 = 6'b100000;

  // Gray value -> one-hot symbol; out-of-alphabet values select nothing.
  function automatic logic [NSYM-1:0] sym_sel(input logic [7:0] d);
    case (d)
      8'd1:    sym_sel = SYM1;
      8'd2:    sym_sel = SYM2;
      8'd3:    sym_sel = SYM3;
      8'd4:    sym_sel = SYM4;
      8'd5:    sym_sel = SYM5;
      8'd6:    sym_sel = SYM6;
      default: sym_sel = '0;
    endcase
  endfunction
endpackage

// File: rtl/huffman_seq_if.sv
// Sample stream, histogram publish and tree-engine handshake of the Huffman sequencer.
interface huffman_seq_if #(parameter int CNT_W = 8);
  logic             gray_valid;
  logic [7:0]       gray_data;
  logic             CNT_valid;
  logic [CNT_W-1:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic             eng_start;
  logic             eng_done;
  logic             code_valid;
  logic             busy;
  logic             err;

  modport master (
    input  gray_valid, gray_data, eng_done,
    output CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
           eng_start, code_valid, busy, err
  );
  modport slave (
    output gray_valid, gray_data, eng_done,
    input  CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
           eng_start, code_valid, busy, err
  );
endinterface

// File: rtl/huffman_hist.sv
// Six saturating symbol counters; clr restarts the histogram and may count on the same edge.
module huffman_hist #(
  parameter int CNT_W = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         clr,
  input  logic                                         en,
  input  logic [huffman_pkg::NSYM-1:0]                 sel,
  output logic [huffman_pkg::NSYM-1:0][CNT_W-1:0]      cnt
);
  import huffman_pkg::*;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < NSYM; k++) begin
        if (clr)
          cnt[k] <= (en && sel[k]) ? CNT_W'(1) : '0;
        else if (en && sel[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end
endmodule

// File: rtl/huffman_seq.sv
// Frame sequencer: histogram a gray frame, publish counts, run the tree engine.
// Optional HUFF_TIMEOUT_EN bounds the engine wait and raises a sticky err.
module huffman_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  huffman_seq_if.master  bus
);
  import huffman_pkg::*;

  state_t                       state;
  logic                         cnt_valid_q, eng_start_q, code_valid_q, busy_q;
  logic [NSYM-1:0][CNT_W-1:0]   cnt;
  logic                         frame_start, hist_en;

  assign frame_start = (state == S_IDLE) && bus.gray_valid;
  assign hist_en     = bus.gray_valid && (state == S_IDLE || state == S_COUNT);

  huffman_hist #(.CNT_W(CNT_W)) u_hist (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_start),
    .en    (hist_en),
    .sel   (sym_sel(bus.gray_data)),
    .cnt   (cnt)
  );

`ifdef HUFF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;
  assign bus.err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt_valid_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef HUFF_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      cnt_valid_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      code_valid_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.gray_valid) begin
          state  <= S_COUNT;
          busy_q <= 1'b1;
`ifdef HUFF_TIMEOUT_EN
          err_q  <= 1'b0;
`endif
        end
        S_COUNT: if (!bus.gray_valid) begin
          state       <= S_REPORT;
          cnt_valid_q <= 1'b1;
        end
        S_REPORT: begin
          state       <= S_LAUNCH;
          eng_start_q <= 1'b1;
        end
        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef HUFF_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // eng_done has priority over a timeout landing on the same edge
        S_WAIT: if (bus.eng_done) begin
          state        <= S_DONE;
          code_valid_q <= 1'b1;
        end
`ifdef HUFF_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state <= S_ERR;
          err_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
`endif
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        S_ERR: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CNT_valid  = cnt_valid_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.code_valid = code_valid_q;
  assign bus.busy       = busy_q;
  assign bus.CNT1 = cnt[0];
  assign bus.CNT2 = cnt[1];
  assign bus.CNT3 = cnt[2];
  assign bus.CNT4 = cnt[3];
  assign bus.CNT5 = cnt[4];
  assign bus.CNT6 = cnt[5];
endmodule
